fpu_dp_add_issue: RTL and testbench
===================================

Name: fpu_dp_add_issue

Overview:
- Operand issue stage directly upstream of the double-precision adder (fpu_dp_adder).
- Accepts (a, b) operand pairs over a valid/ready handshake and classifies each IEEE-754 binary64 operand at enqueue.
- Buffers pairs in a small FIFO. Normal pairs go to the adder; pairs containing zero/denormal/Inf/NaN are resolved here into a ready-made special result, because the adder datapath assumes a hidden 1 and finite exponents.

Parameters:
- DEPTH, 2, FIFO entries; power of two, 2..8.
- CANON_NAN, 64'h7FF8_0000_0000_0000, quiet NaN emitted for every NaN result.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  stage can accept a pair
- in_a  input  64  operand a, binary64
- in_b  input  64  operand b, binary64
- out_valid  output  1  head entry valid
- out_ready  input  1  consumer accepts head
- out_a  output  64  operand a for adder; denormals flushed to signed zero
- out_b  output  64  operand b for adder; denormals flushed to signed zero
- out_special  output  1  head is a special case; adder result must be ignored
- out_special_result  output  64  resolved result when out_special=1, else 0
- out_invalid  output  1  head produced CANON_NAN (invalid operation or NaN input)
- count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (rst_n=0 at a clk edge): count=0, read/write pointers=0, out_valid=0. out_a, out_b, out_special, out_special_result and out_invalid all read 0. Reset wins over a simultaneous push/pop and discards in-flight entries.
- Handshakes:
  - Push when in_valid & in_ready.
  - Pop when out_valid & out_ready.
  - in_ready = (count != DEPTH). A full FIFO does not accept, even if a pop happens in the same cycle.
  - out_valid = (count != 0).
- Latency: a pair accepted at edge N is visible on the out_* ports after edge N (one cycle). Order is strictly FIFO.
- Simultaneous push and pop: count unchanged; both pointers advance. Pointers wrap modulo DEPTH.
- While out_valid & !out_ready, all out_* fields hold stable. When empty, out_* read 0.
- Classification is combinational on in_a/in_b. Results are stored per entry, not recomputed at the head.
  - NaN: exp=7FF, mant!=0.
  - Inf: exp=7FF, mant=0.
  - Zero: exp=0, mant=0.
  - Denormal: exp=0, mant!=0; treated as zero with its sign preserved.
- Special resolution, first matching rule wins:
  1. Either operand NaN -> CANON_NAN, invalid=1.
  2. Both Inf with opposite signs -> CANON_NAN, invalid=1.
  3. Any Inf -> that Inf (same-sign pair gives that Inf), invalid=0.
  4. Both zero -> zero with sign = sign_a & sign_b.
  5. Exactly one zero -> the other operand unchanged.
  6. Else out_special=0, out_special_result=0, out_invalid=0.
- out_a/out_b always carry the (flushed) operands, including for special entries.
- The stage does not compare exponents, normalize or round; that work belongs to the adder.

Test Plan:
- Reset, then push a=3FF0000000000000, b=4000000000000000 with out_ready=1 -> out_valid=1 one cycle later; out_a/out_b equal the inputs; out_special=0; out_invalid=0.
- out_ready=0, push DEPTH pairs back-to-back -> count=DEPTH and in_ready=0. Hold out_ready=0 for 3 cycles -> head stable. Assert out_ready with in_valid held -> pop and push in the same cycle; count stays DEPTH-1 afterwards; order preserved; pointer wrap exercised.
- Push a=7FF0000000000000, b=FFF0000000000000 -> out_special=1, out_special_result=7FF8000000000000, out_invalid=1.
- Push a=8000000000000000, b=8000000000000001 -> out_b=8000000000000000, out_special=1, out_special_result=8000000000000000. Then push a=0000000000000000, b=BFF0000000000000 -> result BFF0000000000000, out_invalid=0.
- Push a=7FF0000000000001, b=3FF0000000000000 -> result 7FF8000000000000, invalid=1. Then push a=FFF0000000000000, b=4000000000000000 -> result FFF0000000000000, invalid=0.
- Fill 2 entries, drive rst_n=0 for one edge while in_valid=1 and out_ready=1 -> count=0, out_valid=0, outputs 0. No entry survives, and the pair offered during reset is not enqueued.

Source files
------------

// File: rtl/fpu_dp_add_issue.sv
// rtl/fpu_dp_add_issue.sv - operand issue FIFO for the binary64 adder with special-case resolution
module fpu_dp_add_issue #(
    parameter int          DEPTH     = 2,
    parameter logic [63:0] CANON_NAN = 64'h7FF8_0000_0000_0000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [63:0]              in_a,
    input  logic [63:0]              in_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [63:0]              out_a,
    output logic [63:0]              out_b,
    output logic                     out_special,
    output logic [63:0]              out_special_result,
    output logic                     out_invalid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] occ;
    logic          push;
    logic          pop;

    logic          a_nan, a_inf, a_zero;
    logic          b_nan, b_inf, b_zero;
    logic [63:0]   flush_a, flush_b;
    logic [63:0]   spec_res;
    logic          spec;
    logic          inv;

    logic [63:0]      mem_a   [DEPTH];
    logic [63:0]      mem_b   [DEPTH];
    logic [63:0]      mem_res [DEPTH];
    logic [DEPTH-1:0] mem_sp;
    logic [DEPTH-1:0] mem_inv;

    assign in_ready  = (occ != FULL);
    assign out_valid = (occ != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign count     = occ;

    // Zero and denormal share a_zero: the adder assumes a hidden 1, so both collapse to signed zero.
    always_comb begin
        a_nan   = (in_a[62:52] == 11'h7FF) && (in_a[51:0] != 52'd0);
        a_inf   = (in_a[62:52] == 11'h7FF) && (in_a[51:0] == 52'd0);
        a_zero  = (in_a[62:52] == 11'h000);
        b_nan   = (in_b[62:52] == 11'h7FF) && (in_b[51:0] != 52'd0);
        b_inf   = (in_b[62:52] == 11'h7FF) && (in_b[51:0] == 52'd0);
        b_zero  = (in_b[62:52] == 11'h000);
        flush_a = a_zero ? {in_a[63], 63'd0} : in_a;
        flush_b = b_zero ? {in_b[63], 63'd0} : in_b;
    end

    always_comb begin
        spec     = 1'b1;
        inv      = 1'b0;
        spec_res = '0;
        if (a_nan || b_nan) begin
            spec_res = CANON_NAN;
            inv      = 1'b1;
        end else if (a_inf && b_inf && (in_a[63] != in_b[63])) begin
            spec_res = CANON_NAN;
            inv      = 1'b1;
        end else if (a_inf) begin
            spec_res = in_a;
        end else if (b_inf) begin
            spec_res = in_b;
        end else if (a_zero && b_zero) begin
            spec_res = {in_a[63] & in_b[63], 63'd0};
        end else if (a_zero) begin
            spec_res = in_b;
        end else if (b_zero) begin
            spec_res = in_a;
        end else begin
            spec = 1'b0;
        end
    end

    // Payload storage needs no reset: the head is masked by out_valid.
    always_ff @(posedge clk) begin
        if (push && rst_n) begin
            mem_a[wr_ptr]   <= flush_a;
            mem_b[wr_ptr]   <= flush_b;
            mem_res[wr_ptr] <= spec_res;
            mem_sp[wr_ptr]  <= spec;
            mem_inv[wr_ptr] <= inv;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_comb begin
        out_a              = '0;
        out_b              = '0;
        out_special        = 1'b0;
        out_special_result = '0;
        out_invalid        = 1'b0;
        if (out_valid) begin
            out_a              = mem_a[rd_ptr];
            out_b              = mem_b[rd_ptr];
            out_special        = mem_sp[rd_ptr];
            out_special_result = mem_res[rd_ptr];
            out_invalid        = mem_inv[rd_ptr];
        end
    end

endmodule

// File: tb/tb_fpu_dp_add_issue.sv
// tb/tb_fpu_dp_add_issue.sv - directed bench with a queue model of the issue stage
module tb_fpu_dp_add_issue;

    localparam int DEPTH = 2;
    localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [63:0]            in_a;
    logic [63:0]            in_b;
    logic                   out_valid;
    logic                   out_ready;
    logic [63:0]            out_a;
    logic [63:0]            out_b;
    logic                   out_special;
    logic [63:0]            out_special_result;
    logic                   out_invalid;
    logic [$clog2(DEPTH):0] count;

    int checks = 0;
    int errors = 0;

    fpu_dp_add_issue #(.DEPTH(DEPTH), .CANON_NAN(QNAN)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
        .out_special(out_special), .out_special_result(out_special_result),
        .out_invalid(out_invalid), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        sp;
        logic [63:0] res;
        logic        inv;
    } exp_t;

    typedef enum {K_NORM, K_ZERO, K_INF, K_NAN} kind_t;

    function automatic kind_t kind_of(logic [63:0] x);
        int unsigned e;
        e = int'(x[62:52]);
        if (e == 2047) return (x[51:0] == 0) ? K_INF : K_NAN;
        if (e == 0) return K_ZERO;
        return K_NORM;
    endfunction

    function automatic exp_t ref_entry(logic [63:0] a, logic [63:0] b);
        exp_t r;
        kind_t ka, kb;
        ka = kind_of(a);
        kb = kind_of(b);
        r.a = (ka == K_ZERO) ? {a[63], 63'd0} : a;
        r.b = (kb == K_ZERO) ? {b[63], 63'd0} : b;
        r.sp = 1'b1;
        r.inv = 1'b0;
        r.res = 64'd0;
        if (ka == K_NAN || kb == K_NAN) begin
            r.res = QNAN; r.inv = 1'b1;
        end else if (ka == K_INF && kb == K_INF && a[63] != b[63]) begin
            r.res = QNAN; r.inv = 1'b1;
        end else if (ka == K_INF || kb == K_INF) begin
            r.res = (ka == K_INF) ? a : b;
        end else if (ka == K_ZERO && kb == K_ZERO) begin
            r.res = {a[63] & b[63], 63'd0};
        end else if (ka == K_ZERO || kb == K_ZERO) begin
            r.res = (ka == K_ZERO) ? b : a;
        end else begin
            r.sp = 1'b0;
        end
        return r;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    exp_t q[$];

    always @(posedge clk) begin
        bit m_push, m_pop;
        if (!rst_n) begin
            q.delete();
        end else begin
            m_push = in_valid && (q.size() != DEPTH);
            m_pop  = (q.size() != 0) && out_ready;
            if (m_pop) void'(q.pop_front());
            if (m_push) q.push_back(ref_entry(in_a, in_b));
        end
    end

    always @(negedge clk) begin
        exp_t h;
        chk("count", 64'(count), 64'(q.size()));
        chk("in_ready", 64'(in_ready), 64'(q.size() != DEPTH));
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            h = q[0];
        end else begin
            h.a = 0; h.b = 0; h.sp = 0; h.res = 0; h.inv = 0;
        end
        chk("out_a", out_a, h.a);
        chk("out_b", out_b, h.b);
        chk("out_special", 64'(out_special), 64'(h.sp));
        chk("out_special_result", out_special_result, h.res);
        chk("out_invalid", 64'(out_invalid), 64'(h.inv));
    end

    task automatic push_check(logic [63:0] a, logic [63:0] b, logic [63:0] ea, logic [63:0] eb,
                              logic esp, logic [63:0] eres, logic einv);
        in_a = a; in_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("dir_valid", 64'(out_valid), 64'd1);
        chk("dir_a", out_a, ea);
        chk("dir_b", out_b, eb);
        chk("dir_special", 64'(out_special), 64'(esp));
        chk("dir_result", out_special_result, eres);
        chk("dir_invalid", 64'(out_invalid), 64'(einv));
        @(posedge clk); #1;
    endtask

    initial begin
        exp_t m;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;

        m = ref_entry(64'h7FF0_0000_0000_0000, 64'hFFF0_0000_0000_0000);
        chk("model_infinf", m.res, QNAN);
        chk("model_infinf_inv", 64'(m.inv), 64'd1);
        m = ref_entry(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001);
        chk("model_denorm_b", m.b, 64'h8000_0000_0000_0000);
        chk("model_negzero", m.res, 64'h8000_0000_0000_0000);
        m = ref_entry(64'hFFF0_0000_0000_0000, 64'h4000_0000_0000_0000);
        chk("model_ninf", m.res, 64'hFFF0_0000_0000_0000);
        m = ref_entry(64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000);
        chk("model_normal", 64'(m.sp), 64'd0);

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_result", out_special_result, 64'd0);

        out_ready = 1'b1;
        @(posedge clk); #1;
        push_check(64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000,
                   64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b0, 64'd0, 1'b0);

        // Fill, hold, then overlap push with pop across the pointer wrap.
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            in_a = 64'h3FF0_0000_0000_0000 + 64'(i);
            in_b = 64'h4000_0000_0000_0000 + 64'(i);
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("full_count", 64'(count), 64'(DEPTH));
            chk("full_ready", 64'(in_ready), 64'd0);
            chk("hold_a", out_a, 64'h3FF0_0000_0000_0000);
        end
        @(posedge clk); #1;
        in_a = 64'h3FF0_0000_0000_0010; in_b = 64'h4000_0000_0000_0010;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pop_only_count", 64'(count), 64'(DEPTH - 1));
        @(posedge clk); #1;
        in_a = 64'h3FF0_0000_0000_0011; in_b = 64'h4000_0000_0000_0011;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("pushpop_count", 64'(count), 64'(DEPTH - 1));
        repeat (DEPTH + 1) @(posedge clk);
        #1;

        push_check(64'h7FF0_0000_0000_0000, 64'hFFF0_0000_0000_0000,
                   64'h7FF0_0000_0000_0000, 64'hFFF0_0000_0000_0000, 1'b1, QNAN, 1'b1);
        push_check(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001,
                   64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1,
                   64'h8000_0000_0000_0000, 1'b0);
        push_check(64'h0000_0000_0000_0000, 64'hBFF0_0000_0000_0000,
                   64'h0000_0000_0000_0000, 64'hBFF0_0000_0000_0000, 1'b1,
                   64'hBFF0_0000_0000_0000, 1'b0);
        push_check(64'h7FF0_0000_0000_0001, 64'h3FF0_0000_0000_0000,
                   64'h7FF0_0000_0000_0001, 64'h3FF0_0000_0000_0000, 1'b1, QNAN, 1'b1);
        push_check(64'hFFF0_0000_0000_0000, 64'h4000_0000_0000_0000,
                   64'hFFF0_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b1,
                   64'hFFF0_0000_0000_0000, 1'b0);
        push_check(64'h0000_0000_0000_0000, 64'h8000_0000_0000_0000,
                   64'h0000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 64'd0, 1'b0);

        // Reset with traffic offered: nothing survives and nothing new is taken.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_a = 64'h4010_0000_0000_0000 + 64'(i);
            in_b = 64'h4020_0000_0000_0000;
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_a = 64'h4030_0000_0000_0000;
        in_valid = 1'b1; out_ready = 1'b1; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        chk("rst2_count", 64'(count), 64'd0);
        chk("rst2_valid", 64'(out_valid), 64'd0);
        chk("rst2_a", out_a, 64'd0);
        chk("rst2_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        chk("rst2_still_empty", 64'(out_valid), 64'd0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
